// File: rtl/breath_sequencer_if.sv
// -----------------------------------------------------------------------------
// breath_sequencer_if
// Bundles the run request and the observable outputs of the breathing-light
// sequencer.
//   en    : run request driven by the controller (master)
//   led   : registered PWM pin from the sequencer (slave)
//   check : one-cycle end-of-breath pulse
//   duty  : current duty register, PWM_BITS wide
//   state : FSM state code (IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DOWN=3, HOLD_LO=4)
// -----------------------------------------------------------------------------
interface breath_sequencer_if #(
    parameter int PWM_BITS = 8
);
    logic                en;
    logic                led;
    logic                check;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          state;

    modport master (output en, input led, input check, input duty, input state);
    modport slave  (input en, output led, output check, output duty, output state);
endinterface

// File: rtl/breath_sequencer.sv
// -----------------------------------------------------------------------------
// breath_sequencer
// Breathing-light controller. A free-running PWM counter compares against a
// duty register; the FSM ramps duty up, holds at peak, ramps down, holds dark,
// and pulses check for one clock at the end of every breath. Dropping en lets
// the current breath finish before returning to IDLE.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   bus   : breath_sequencer_if.slave (en in; led, check, duty, state out)
// -----------------------------------------------------------------------------
module breath_sequencer #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_CYCLES  = 4,
    parameter int HOLD_PERIODS = 8
) (
    input  logic              clk,
    input  logic              rst,
    breath_sequencer_if.slave bus
);

    localparam int STEP_W = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RAMP_UP   = 3'd1;
    localparam logic [2:0] S_HOLD_HI   = 3'd2;
    localparam logic [2:0] S_RAMP_DOWN = 3'd3;
    localparam logic [2:0] S_HOLD_LO   = 3'd4;

    logic [2:0]          state_q,    state_d;
    logic [PWM_BITS-1:0] duty_q,     duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                led_q,      led_d;
    logic                check_q,    check_d;

    logic active_s;
    logic period_end_s;
    logic step_s;
    logic hold_done_s;
    logic ramp_s;
    logic hold_s;

    // PWM datapath: counter, period/step/hold strobes and next pin value
    always_comb begin
        active_s     = (state_q != S_IDLE);
        ramp_s       = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
        hold_s       = (state_q == S_HOLD_HI) || (state_q == S_HOLD_LO);
        period_end_s = active_s && (pwm_cnt_q == PWM_MAX);
        step_s       = period_end_s && ramp_s && (step_cnt_q == STEP_LAST);
        hold_done_s  = period_end_s && hold_s && (hold_cnt_q == HOLD_LAST);
        if (active_s) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end else begin
            pwm_cnt_d = PWM_ZERO;
        end
        // Compare uses the current counter, so the pin lags pwm_cnt by one clock
        led_d = active_s && (pwm_cnt_q < duty_q);
    end

    // Breath FSM: state sequencing, duty stepping and end-of-breath pulse
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        check_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                duty_d = PWM_ZERO;
                if (bus.en) begin
                    state_d = S_RAMP_UP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAMP_UP: begin
                // The step that finds duty already at MAX spends a full extra
                // step interval at peak before leaving the ramp
                if (step_s && (duty_q == PWM_MAX)) begin
                    state_d = S_HOLD_HI;
                end else if (step_s) begin
                    duty_d = duty_q + PWM_BITS'(1);
                end else begin
                    duty_d = duty_q;
                end
            end
            S_HOLD_HI: begin
                if (hold_done_s) begin
                    state_d = S_RAMP_DOWN;
                end else begin
                    state_d = S_HOLD_HI;
                end
            end
            S_RAMP_DOWN: begin
                if (step_s && (duty_q == PWM_ZERO)) begin
                    state_d = S_HOLD_LO;
                end else if (step_s) begin
                    duty_d = duty_q - PWM_BITS'(1);
                end else begin
                    duty_d = duty_q;
                end
            end
            S_HOLD_LO: begin
                // en is only looked at here, which is what makes a stop graceful
                if (hold_done_s) begin
                    check_d = 1'b1;
                    if (bus.en) begin
                        state_d = S_RAMP_UP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
                duty_d  = PWM_ZERO;
            end
        endcase
    end

    // Step and hold period counters, cleared on every state change
    always_comb begin
        step_cnt_d = step_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q) begin
            step_cnt_d = {STEP_W{1'b0}};
            hold_cnt_d = {HOLD_W{1'b0}};
        end else if (period_end_s && ramp_s) begin
            if (step_s) begin
                step_cnt_d = {STEP_W{1'b0}};
            end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end
        end else if (period_end_s && hold_s) begin
            if (hold_done_s) begin
                hold_cnt_d = {HOLD_W{1'b0}};
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end else begin
            step_cnt_d = step_cnt_q;
            hold_cnt_d = hold_cnt_q;
        end
    end

    // State register bank with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            duty_q     <= PWM_ZERO;
            pwm_cnt_q  <= PWM_ZERO;
            step_cnt_q <= {STEP_W{1'b0}};
            hold_cnt_q <= {HOLD_W{1'b0}};
            led_q      <= 1'b0;
            check_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            led_q      <= led_d;
            check_q    <= check_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.check = check_q;
    assign bus.duty  = duty_q;
    assign bus.state = state_q;

endmodule

// File: doc/breath_sequencer.md
Name: breath_sequencer

Overview:
Breathing-light controller that sequences a PWM brightness datapath. It owns a free-running PWM counter and a duty register, and ramps duty up, holds at peak, ramps down, then holds dark. It repeats this while enabled and drives the LED pin directly. A one-cycle check pulse at the end of each breath lets the top level and the bench count completed cycles.

Parameters:
PWM_BITS, 8, width of PWM counter and duty; PWM period = 2^PWM_BITS clocks; MAX = 2^PWM_BITS-1
STEP_CYCLES, 4, PWM periods per duty step (>=1)
HOLD_PERIODS, 8, PWM periods spent in each hold state (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  run request; sampled every clock
led  output  1  registered PWM output to LED
check  output  1  one-cycle pulse at end of each full breath
duty  output  PWM_BITS  current duty register
state  output  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DOWN=3, HOLD_LO=4

Behaviour:
- Reset (rst=0, async): state=IDLE, duty=0, pwm_cnt=0, step_cnt=0, hold_cnt=0, led=0, check=0. All outputs are held there until rst returns high. Reset mid-breath aborts immediately with no check pulse.
- pwm_cnt: increments by 1 every clock in any non-IDLE state and wraps MAX->0. It is forced to 0 in IDLE. period_end = (pwm_cnt==MAX) in a non-IDLE state.
- led <= (state!=IDLE) && (pwm_cnt < duty). This gives one clock of latency from pwm_cnt/duty to the pin.
  - duty=0: led is never high.
  - duty=MAX: led is high MAX of every 2^PWM_BITS clocks.
- step: step_cnt counts period_ends in ramp states. When period_end occurs and step_cnt==STEP_CYCLES-1, step=1 and step_cnt clears to 0; otherwise step_cnt increments on period_end.
- hold: hold_cnt counts period_ends in hold states. hold_done = period_end && hold_cnt==HOLD_PERIODS-1, and hold_cnt then clears.
- step_cnt and hold_cnt are both cleared on every state transition.
- IDLE: if en=1, go to RAMP_UP on the next clock with all counters at 0 and duty=0.
- RAMP_UP: on step, if duty==MAX go to HOLD_HI (duty stays MAX); else duty<=duty+1.
- HOLD_HI: on hold_done, go to RAMP_DOWN.
- RAMP_DOWN: on step, if duty==0 go to HOLD_LO; else duty<=duty-1.
- HOLD_LO: on hold_done, check<=1 for exactly one clock. In the same cycle, go to RAMP_UP if en=1, else IDLE.
- check is 0 in all other cycles.
- en deassert: graceful stop. The current breath completes and the block returns to IDLE after the HOLD_LO check pulse. Re-asserting en before then cancels the stop.
- en edges: en toggling inside a breath has no other effect. en=1 in IDLE takes effect on the next edge.
- duty arithmetic: never wraps; it saturates at 0/MAX by construction of the transitions.
- Breath length from RAMP_UP entry to the check edge: (2*(MAX+1)*STEP_CYCLES + 2*HOLD_PERIODS) * 2^PWM_BITS clocks.

Test Plan:
- Reset: hold rst=0 for 100 ns with en=1, clk 20 ns period -> state=0, duty=0, led=0, check=0. Assert rst=0 mid-RAMP_UP -> all outputs are 0 in the same cycle, with no check pulse.
- Full breath, PWM_BITS=4, STEP_CYCLES=1, HOLD_PERIODS=2, en=1 -> state 1->2->3->4. Duty climbs 0..15 by 1 every 16 clocks, then falls 15..0. check is high for exactly 1 clock, 576 clocks after RAMP_UP entry. State is back at 1 the following cycle.
- PWM duty check, same params: at duty=5, sample led over one period -> exactly 5 highs in 16 clocks, lagging pwm_cnt by 1 clock. At duty=0 -> 0 highs. At duty=15 -> 15 highs.
- Graceful stop: drop en during HOLD_HI -> breath continues through RAMP_DOWN/HOLD_LO. check pulses once, then state=0 with duty=0 and led=0, and stays idle for 1000 clocks.
- Stop cancel and restart: drop en in RAMP_DOWN and re-raise it before HOLD_LO ends -> no IDLE visit, and a second check pulse comes 576 clocks after the first. Raising en from IDLE -> state=1 on the next edge.
- Defaults (PWM_BITS=8, STEP_CYCLES=4, HOLD_PERIODS=8) -> duty increments every 1024 clocks. check period is (2048+16)*256 = 528384 clocks.
